// File: rtl/debounce_filter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | debounce_filter: synchronizes a bouncing input and accepts a level     |
// | change only after CNT_MAX+1 stable samples. Optional rise/fall strobes |
// | are enabled by defining DEBOUNCE_FILTER_STROBE_EN.                     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module debounce_filter #(
  parameter int CNT_MAX     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int            CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dout_q, dout_d;
  logic                   sync;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign sync   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      S_LOW: begin
        dout_d = 1'b0;
        if (sync) begin
          state_d = S_WAIT_H;
          cnt_d   = '0;
        end
      end
      S_WAIT_H: begin
        if (!sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          dout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        dout_d = 1'b1;
        if (!sync) begin
          state_d = S_WAIT_L;
          cnt_d   = '0;
        end
      end
      S_WAIT_L: begin
        if (sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          dout_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      sync_q  <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q == S_WAIT_H) || (state_q == S_WAIT_L);

`ifdef DEBOUNCE_FILTER_STROBE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Strobes fire on the same qualifying sample that flips dout.
  always_comb begin
    rise_d = (state_q == S_WAIT_H) && sync  && (cnt_q == CNT_LAST);
    fall_d = (state_q == S_WAIT_L) && !sync && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/debounce_filter.md
# debounce_filter

- Upstream conditioning stage for the D flip-flop storage element; sits between an asynchronous, bouncing one-bit source (push-button, switch) and the flip-flop `D` input.
- Synchronizes the raw input into the `clk` domain and accepts a level change only after the synchronized value has been stable for a programmable number of cycles.
- Drives a clean level plus optional one-cycle rise/fall strobes, so the downstream flip-flop never sees glitches or metastable values.

## Interface
- `CNT_MAX`, default 8: consecutive stable cycles required in the WAIT state to accept a change; legal range ≥ 1.
- `SYNC_STAGES`, default 2: synchronizer depth in flops; legal range ≥ 2.
- Clock/reset (decided): single clock; reset asynchronous, active-high.
- `clk` input, 1: rising-edge clock, 10 ns nominal period.
- `rst` input, 1: asynchronous active-high reset.
- `din` input, 1: raw asynchronous input, may bounce.
- `dout` output, 1: debounced level; feeds the flip-flop `D`.
- `rise` output, 1: one-cycle strobe when `dout` goes 0→1.
- `fall` output, 1: one-cycle strobe when `dout` goes 1→0.
- `busy` output, 1: high while a candidate change is being qualified.

## Operation
- **Synchronizer**
  - Chain of `SYNC_STAGES` flops on `din`; its last stage is `sync`.
  - All stages reset to 0.
- **Counter**
  - `cnt` is `$clog2(CNT_MAX+1)` bits wide, unsigned.
  - Cleared on every state entry; never wraps.
- **FSM, 4 states, reset state S_LOW**
  - S_LOW (`dout`=0): `sync`=1 → S_WAIT_H with `cnt`←0; otherwise stay.
  - S_WAIT_H (`dout`=0, `busy`=1):
    - `sync`=0 → S_LOW, `cnt`←0. Glitch rejected, no strobe.
    - `sync`=1 and `cnt`=CNT_MAX-1 → S_HIGH; `dout`←1, `rise`←1.
    - Otherwise `cnt`←`cnt`+1.
  - S_HIGH (`dout`=1): `sync`=0 → S_WAIT_L with `cnt`←0; otherwise stay.
  - S_WAIT_L (`dout`=1, `busy`=1): mirror of S_WAIT_H.
    - `sync`=1 → S_HIGH.
    - `sync`=0 and `cnt`=CNT_MAX-1 → S_LOW; `dout`←0, `fall`←1.
- **Outputs**
  - `dout`, `rise`, `fall` are registered.
  - `busy` is decoded from the state register.
- **Strobes**
  - `rise` and `fall` are high for exactly one cycle.
  - They are never high together and never high in consecutive cycles.
- **Reset mid-operation**
  - Asynchronously forces S_LOW, `cnt`=0, synchronizer=0, and `dout`/`rise`/`fall`/`busy`=0, regardless of state.
  - No strobe is generated by reset.
  - If `din`=1 across reset release, a normal qualified rise follows.

## Timing
- Reset values: `dout`=0, `rise`=0, `fall`=0, `busy`=0.
- Acceptance latency, counting the first edge that samples the new `din` as edge 1:
  - `dout` and the strobe change at edge `SYNC_STAGES`+1+`CNT_MAX`.
  - Defaults: edge 11 (110 ns at 10 ns period).
- Qualification window: `sync` must hold the new value for `CNT_MAX`+1 consecutive samples (1 in the stable state, `CNT_MAX` in WAIT).
- Stable-time boundaries:
  - Any opposite sample inside the window aborts it with no output change.
  - A pulse of `CNT_MAX` samples or fewer is always rejected.
- `busy` rises at edge `SYNC_STAGES`+1 and falls on the same edge that `dout` changes (or on abort).
- No combinational path from `din` to any output.

## Configuration
- Macro: `DEBOUNCE_FILTER_STROBE_EN`.
- Defined: `rise`/`fall` registers and logic are present as described above.
- Undefined:
  - No strobe flops are synthesized; `rise` and `fall` are tied to constant 0.
  - `dout`, `busy`, latency and FSM are unchanged.

## Test plan
- Reset: `rst`=1 for 3 cycles with `din`=1, then release → all outputs 0 during reset; `dout`=1 and `rise` pulse at edge 11 after release (defaults).
- Clean press: `din` 0→1 held 200 ns → `dout`=1 at edge 11, `rise` high exactly one cycle, `busy` high edges 3–10.
- Bounce: `din` toggles every 20 ns for 100 ns, then holds 1 → no change on `dout`/`rise` during bouncing; `dout`=1 at 11 edges after the last transition.
- Boundary glitch: `din` high for exactly 10 cycles (sync high 9 samples, `CNT_MAX`=8) → accepted; high for 8 cycles → rejected, `dout` stays 0, `busy` returns 0.
- Release: from `dout`=1, `din`→0 held → `dout`=0 and `fall` one-cycle pulse at edge 11; with macro undefined, `rise`=`fall`=0 throughout.
- Reset mid-qualification: assert `rst` while `busy`=1 with `cnt`=5 → `busy`, `dout`, `cnt` cleared immediately, without waiting for a clock edge; no strobe.
